// File: rtl/mem_arbiter_if.sv
// Client and Memory signal bundle for mem_arbiter.
// slave is the arbiter's view; master is the clients'/Memory's view.
interface mem_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int DinLENGTH = 32
);
  logic                 Req0, Req1;
  logic                 Rw0, Rw1;
  logic [WIDTH-1:0]     Addr0, Addr1;
  logic [DinLENGTH-1:0] Wdata0, Wdata1;
  logic                 Ack0, Ack1;
  logic [DinLENGTH-1:0] Rdata;
  logic                 Busy;
  logic                 Mem_Valid;
  logic                 Mem_R_W;
  logic [WIDTH-1:0]     Mem_Addr;
  logic [DinLENGTH-1:0] Mem_Din;
  logic [DinLENGTH-1:0] Mem_Dout;

  modport slave (
    input  Req0, Req1, Rw0, Rw1, Addr0, Addr1, Wdata0, Wdata1, Mem_Dout,
    output Ack0, Ack1, Rdata, Busy, Mem_Valid, Mem_R_W, Mem_Addr, Mem_Din
  );

  modport master (
    output Req0, Req1, Rw0, Rw1, Addr0, Addr1, Wdata0, Wdata1, Mem_Dout,
    input  Ack0, Ack1, Rdata, Busy, Mem_Valid, Mem_R_W, Mem_Addr, Mem_Din
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client arbiter/sequencer for the single-port Memory: IDLE -> ISSUE -> (WAIT) -> DONE.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module mem_arbiter #(
  parameter int WIDTH     = 8,
  parameter int DinLENGTH = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 cmd_port_reg, cmd_port_next;
  logic                 cmd_rw_reg, cmd_rw_next;
  logic [WIDTH-1:0]     cmd_addr_reg, cmd_addr_next;
  logic [DinLENGTH-1:0] cmd_din_reg, cmd_din_next;
  logic                 valid_reg, valid_next;
  logic                 ack0_reg, ack0_next;
  logic                 ack1_reg, ack1_next;
  logic [DinLENGTH-1:0] rdata_reg, rdata_next;
  logic                 grant_port;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic                 ptr_reg, ptr_next;
`endif

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    grant_port = ~bus.Req0;
`else
    grant_port = (bus.Req0 && bus.Req1) ? ptr_reg : bus.Req1;
`endif
  end

  // The command register doubles as the Memory output register, so Mem_* holds between accesses.
  always_comb begin
    state_next    = state_reg;
    cmd_port_next = cmd_port_reg;
    cmd_rw_next   = cmd_rw_reg;
    cmd_addr_next = cmd_addr_reg;
    cmd_din_next  = cmd_din_reg;
    valid_next    = 1'b0;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    rdata_next    = rdata_reg;
`ifndef MEM_ARB_FIXED_PRIO_EN
    ptr_next      = ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          cmd_port_next = grant_port;
          cmd_rw_next   = grant_port ? bus.Rw1    : bus.Rw0;
          cmd_addr_next = grant_port ? bus.Addr1  : bus.Addr0;
          cmd_din_next  = grant_port ? bus.Wdata1 : bus.Wdata0;
          valid_next    = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_rw_reg) begin
          ack0_next  = ~cmd_port_reg;
          ack1_next  = cmd_port_reg;
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Memory's registered Dout is only driven in this cycle.
        rdata_next = bus.Mem_Dout;
        ack0_next  = ~cmd_port_reg;
        ack1_next  = cmd_port_reg;
        state_next = DONE;
      end
      DONE: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
        ptr_next   = ~cmd_port_reg;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      cmd_port_reg <= 1'b0;
      cmd_rw_reg   <= 1'b0;
      cmd_addr_reg <= '0;
      cmd_din_reg  <= '0;
      valid_reg    <= 1'b0;
      ack0_reg     <= 1'b0;
      ack1_reg     <= 1'b0;
      rdata_reg    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cmd_port_reg <= cmd_port_next;
      cmd_rw_reg   <= cmd_rw_next;
      cmd_addr_reg <= cmd_addr_next;
      cmd_din_reg  <= cmd_din_next;
      valid_reg    <= valid_next;
      ack0_reg     <= ack0_next;
      ack1_reg     <= ack1_next;
      rdata_reg    <= rdata_next;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_reg      <= ptr_next;
`endif
    end
  end

  assign bus.Ack0      = ack0_reg;
  assign bus.Ack1      = ack1_reg;
  assign bus.Rdata     = rdata_reg;
  assign bus.Busy      = (state_reg != IDLE);
  assign bus.Mem_Valid = valid_reg;
  assign bus.Mem_R_W   = cmd_rw_reg;
  assign bus.Mem_Addr  = cmd_addr_reg;
  assign bus.Mem_Din   = cmd_din_reg;
endmodule
